// File: rtl/akp_stream_rx.sv
// AKP stream receiver: checks sop/eop framing and line length, buffers 192-bit
// result words in a small FIFO and serializes each into six 32-bit beats.
module akp_stream_rx #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             ink,
  input  logic                             data_valid,
  input  logic                             sop,
  input  logic                             eop,
  input  logic [191:0]                     din,
  input  logic [11:0]                      L_stroke,
  output logic [31:0]                      dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic                             dout_sop,
  output logic                             dout_eop,
  output logic                             frame_done,
  output logic                             frame_err,
  output logic                             len_err,
  output logic                             ovf,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 194;

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state;
  logic [11:0]     cnt;
  logic [11:0]     cnt_inc;
  logic            wq_en;
  logic [EW-1:0]   wq_data;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            rd_en;
  logic [EW-1:0]   rd_data;

  logic [191:0]    sr;
  logic [2:0]      idx;
  logic            ent_eop;
  logic            hs;
  logic            load;

  assign cnt_inc = (cnt == 12'hFFF) ? cnt : cnt + 12'd1;

  // Framing FSM; accepted words go through a one-entry write stage into the FIFO.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= 12'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      len_err    <= 1'b0;
      wq_en      <= 1'b0;
      wq_data    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      len_err    <= 1'b0;
      wq_en      <= 1'b0;
      if (ink) begin
        frame_err <= (state == RECV);
        state     <= IDLE;
        cnt       <= 12'd0;
      end else if (data_valid) begin
        if (sop) begin
          frame_err <= (state == RECV);
          wq_en     <= 1'b1;
          wq_data   <= {1'b1, eop, din};
          cnt       <= 12'd1;
          if (eop) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            len_err    <= (L_stroke != 12'd0) && (L_stroke != 12'd1);
          end else begin
            state <= RECV;
          end
        end else if (state == IDLE) begin
          frame_err <= 1'b1;
        end else begin
          wq_en   <= 1'b1;
          wq_data <= {1'b0, eop, din};
          cnt     <= cnt_inc;
          if (eop) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            len_err    <= (L_stroke != 12'd0) && (L_stroke != cnt_inc);
          end
        end
      end
    end
  end

  assign full    = (fifo_level == LW'(DEPTH));
  assign empty   = (fifo_level == LW'(0));
  assign rd_en   = load;
  // A same-edge read frees a slot, so a full FIFO still accepts the write.
  assign wr_en   = wq_en && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wq_data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (wq_en && !wr_en) ovf <= 1'b1;
    end
  end

  assign hs   = dout_valid && dout_ready;
  assign load = !empty && (!dout_valid || (hs && idx == 3'd5));
  assign dout = sr[191:160];

  // Serializer: shifts the held word left one beat per handshake.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr         <= '0;
      idx        <= 3'd0;
      ent_eop    <= 1'b0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (load) begin
      sr         <= rd_data[191:0];
      idx        <= 3'd0;
      ent_eop    <= rd_data[192];
      dout_valid <= 1'b1;
      dout_sop   <= rd_data[193];
      dout_eop   <= 1'b0;
    end else if (hs) begin
      if (idx == 3'd5) begin
        dout_valid <= 1'b0;
        dout_sop   <= 1'b0;
        dout_eop   <= 1'b0;
      end else begin
        sr       <= {sr[159:0], 32'd0};
        idx      <= idx + 3'd1;
        dout_sop <= 1'b0;
        dout_eop <= ent_eop && (idx == 3'd4);
      end
    end
  end

endmodule

// File: tb/tb_akp_stream_rx.sv
// Directed bench for akp_stream_rx: framing, length check, overflow, ink abort, clr.
module tb_akp_stream_rx;

  logic         clk = 1'b0;
  logic         clr;
  logic         ink;
  logic         data_valid;
  logic         sop;
  logic         eop;
  logic [191:0] din;
  logic [11:0]  L_stroke;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_sop;
  logic         dout_eop;
  logic         frame_done;
  logic         frame_err;
  logic         len_err;
  logic         ovf;
  logic [2:0]   fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_ferr  = 0;
  int n_lerr  = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];

  akp_stream_rx #(.DEPTH(4)) dut (
    .clk(clk), .clr(clr), .ink(ink), .data_valid(data_valid), .sop(sop), .eop(eop),
    .din(din), .L_stroke(L_stroke), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .frame_done(frame_done), .frame_err(frame_err), .len_err(len_err), .ovf(ovf),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Record every accepted beat and every status pulse.
  always @(posedge clk) begin
    if (!clr) begin
      if (dout_valid && dout_ready) got_q.push_back({dout_sop, dout_eop, dout});
      if (frame_done) n_done++;
      if (frame_err)  n_ferr++;
      if (len_err)    n_lerr++;
    end
  end

  function automatic logic [191:0] mk(input int n);
    logic [191:0] w;
    for (int j = 0; j < 6; j++) w[191-32*j -: 32] = {8'hC0, 8'(n), 8'h5A, 8'(j)};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic e, input int n);
    data_valid = 1'b1;
    sop        = s;
    eop        = e;
    din        = mk(n);
  endtask

  task automatic idle_in();
    data_valid = 1'b0;
    sop        = 1'b0;
    eop        = 1'b0;
    ink        = 1'b0;
  endtask

  task automatic exp_word(input int n, input logic s, input logic e);
    logic [191:0] w;
    w = mk(n);
    for (int j = 0; j < 6; j++)
      exp_q.push_back({s && (j == 0), e && (j == 5), w[191-32*j -: 32]});
  endtask

  task automatic clear_counts();
    n_done = 0;
    n_ferr = 0;
    n_lerr = 0;
  endtask

  task automatic drain(input string tag);
    logic ok;
    ok = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 400; i++) begin
      if (fifo_level == 3'd0 && !dout_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_drained"}, 64'(ok), 64'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    clr = 1'b1; ink = 1'b0; data_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    din = '0; L_stroke = 12'd0; dout_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    chk("rst_dout",  64'(dout), 64'd0);
    chk("rst_flags", 64'({dout_sop, dout_eop, frame_done, frame_err, len_err}), 64'd0);
    clr = 1'b0;
    tick();

    // Three-word frame matching L_stroke; latency two edges.
    clear_counts();
    L_stroke = 12'd3;
    drive(1'b1, 1'b0, 1); exp_word(1, 1'b1, 1'b0);
    tick();
    chk("t1_lat0", 64'(dout_valid), 64'd0);
    drive(1'b0, 1'b0, 2); exp_word(2, 1'b0, 1'b0);
    tick();
    chk("t1_lat1", 64'(dout_valid), 64'd0);
    drive(1'b0, 1'b1, 3); exp_word(3, 1'b0, 1'b1);
    tick();
    chk("t1_lat2", 64'(dout_valid), 64'd1);
    chk("t1_first", 64'(dout), 64'h0000_0000_C001_5A00);
    chk("t1_sop", 64'(dout_sop), 64'd1);
    chk("t1_done", 64'(frame_done), 64'd1);
    chk("t1_len", 64'(len_err), 64'd0);
    idle_in();
    drain("t1");
    chk("t1_ndone", 64'(n_done), 64'd1);
    chk("t1_nerr", 64'(n_ferr + n_lerr), 64'd0);
    cmp_stream("t1");

    // Short frame: length error but data still forwarded.
    clear_counts();
    drive(1'b1, 1'b0, 11); exp_word(11, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 12); exp_word(12, 1'b0, 1'b1);
    tick();
    chk("t2_len", 64'(len_err), 64'd1);
    chk("t2_done", 64'(frame_done), 64'd1);
    idle_in();
    tick();
    chk("t2_len_pulse", 64'(len_err), 64'd0);
    drain("t2");
    chk("t2_nlen", 64'(n_lerr), 64'd1);
    cmp_stream("t2");

    // Back-pressure: six words into one serializer slot plus four FIFO entries.
    clear_counts();
    dout_ready = 1'b0;
    L_stroke = 12'd6;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, i == 5, 21 + i);
      if (i < 5) exp_word(21 + i, i == 0, 1'b0);
      tick();
    end
    idle_in();
    tick();
    tick();
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_level", 64'(fifo_level), 64'd4);
    chk("t3_valid", 64'(dout_valid), 64'd1);
    chk("t3_hold0", 64'({dout_sop, dout}), 64'h1_C015_5A00);
    tick();
    tick();
    tick();
    chk("t3_hold1", 64'({dout_sop, dout_eop, dout}), 64'h2_C015_5A00);
    chk("t3_ndone", 64'(n_done), 64'd1);
    chk("t3_nlen", 64'(n_lerr), 64'd0);
    dout_ready = 1'b1;
    drain("t3");
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);
    cmp_stream("t3");

    // Stray word in IDLE is discarded with a framing error.
    clear_counts();
    drive(1'b0, 1'b0, 31);
    tick();
    chk("t4_ferr", 64'(frame_err), 64'd1);
    idle_in();
    tick();
    chk("t4_ferr_pulse", 64'(frame_err), 64'd0);
    tick();
    chk("t4_level", 64'(fifo_level), 64'd0);
    chk("t4_valid", 64'(dout_valid), 64'd0);
    chk("t4_ovf", 64'(ovf), 64'd1);

    // ink aborts an open frame; coincident word dropped; later frames clean.
    clear_counts();
    L_stroke = 12'd2;
    drive(1'b1, 1'b0, 41); exp_word(41, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 42); exp_word(42, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 43);
    ink = 1'b1;
    tick();
    chk("t5_ink_ferr", 64'(frame_err), 64'd1);
    idle_in();
    tick();
    chk("t5_ferr_pulse", 64'(frame_err), 64'd0);
    drive(1'b1, 1'b0, 44); exp_word(44, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 45); exp_word(45, 1'b0, 1'b1);
    tick();
    chk("t5_clean", 64'({frame_done, frame_err, len_err}), 64'b100);
    L_stroke = 12'd1;
    drive(1'b1, 1'b1, 46); exp_word(46, 1'b1, 1'b1);
    tick();
    chk("t5_single", 64'({frame_done, frame_err, len_err}), 64'b100);
    idle_in();
    drain("t5");
    chk("t5_counts", 64'({8'(n_done), 8'(n_ferr), 8'(n_lerr)}), 64'h02_01_00);
    cmp_stream("t5");

    // clr during serialization at beat index 3.
    L_stroke = 12'd0;
    drive(1'b1, 1'b0, 51);
    tick();
    drive(1'b0, 1'b1, 52);
    tick();
    idle_in();
    tick();
    chk("t6_valid", 64'(dout_valid), 64'd1);
    tick();
    tick();
    tick();
    chk("t6_idx3", 64'(dout), 64'hC033_5A03);
    chk("t6_level_pre", 64'(fifo_level), 64'd1);
    clr = 1'b1;
    #1;
    chk("t6_clr_valid", 64'(dout_valid), 64'd0);
    chk("t6_clr_level", 64'(fifo_level), 64'd0);
    chk("t6_clr_ovf", 64'(ovf), 64'd0);
    tick();
    clr = 1'b0;
    got_q.delete();
    exp_q.delete();
    tick();
    drive(1'b1, 1'b1, 61); exp_word(61, 1'b1, 1'b1);
    tick();
    idle_in();
    tick();
    tick();
    chk("t6_restart", 64'({dout_valid, dout_sop, dout}), 64'h3_C03D_5A00);
    drain("t6");
    cmp_stream("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/akp_stream_rx.md
# akp_stream_rx

Receive side of the AKP packet stream: accepts 192-bit canceller result words framed by `sop`/`eop`/`data_valid`, checks framing and line length against `L_stroke`, buffers words in a small FIFO, and serializes each word into six 32-bit words on a valid/ready interface toward the host/recorder path. Sits directly downstream of the AKP output port, on the same `clk`.

## Interface
- `DEPTH`, 4: FIFO depth in 192-bit words (power of two, ≥2).
- `clk` in 1: single system clock, all logic on rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `ink` in 1: line-start strobe (single-cycle), aborts any open frame.
- `data_valid` in 1: `din` valid this cycle.
- `sop` in 1: first word of frame; sampled only when `data_valid`=1.
- `eop` in 1: last word of frame; sampled only when `data_valid`=1.
- `din` in 192: {UP_RE, UP_IM, DN_RE, DN_IM, PEL_RE, PEL_IM}, 32 bits each, UP_RE in [191:160].
- `L_stroke` in 12: expected words per frame; 0 disables length check.
- `dout` out 32: serialized sub-word.
- `dout_valid` out 1: `dout` valid.
- `dout_ready` in 1: downstream accepts when high with `dout_valid`.
- `dout_sop` out 1: first sub-word of a frame.
- `dout_eop` out 1: last sub-word of a frame.
- `frame_done` out 1: one-cycle pulse, eop word accepted.
- `frame_err` out 1: one-cycle pulse, framing violation.
- `len_err` out 1: one-cycle pulse, length mismatch at eop.
- `ovf` out 1: sticky, word dropped on full FIFO; cleared only by `clr`.
- `fifo_level` out clog2(DEPTH+1): stored words.

## Operation
- Input FSM states IDLE, RECV. Reset → IDLE, word counter `cnt` (12 bit, saturating at 4095) = 0.
- IDLE: `data_valid&sop` → write word, `cnt`=1; if `eop` also set (single-word frame) stay IDLE, run eop check with cnt=1; else → RECV. `data_valid&!sop` → word discarded, `frame_err` pulse.
- RECV: `data_valid&!sop` → write word, `cnt`+1; if `eop` → IDLE, eop check. `data_valid&sop` → `frame_err` pulse, word written as new frame start, `cnt`=1 (stays RECV, or IDLE if eop).
- Eop check: `frame_done` pulse; `len_err` pulse if `L_stroke`≠0 and final `cnt`≠`L_stroke`. Data is forwarded regardless of errors.
- `ink`=1: FSM → IDLE, `cnt`=0; `frame_err` pulse if state was RECV. `ink` has priority: a coincident `data_valid` word is discarded with no further error. FIFO not flushed.
- FIFO entries 194 bits: `din` plus sop/eop flags. Write with FIFO full → word dropped, `ovf` set; FSM/counter still advance as if written.
- Serializer: holds one entry in a 192-bit shift register with 3-bit index 0..5. Emits [191:160] first, [31:0] last. `dout_sop` = entry sop flag & index 0; `dout_eop` = entry eop flag & index 5.
- Index advances only on `dout_valid&dout_ready`. Handshake at index 5 loads next entry in the same edge if FIFO non-empty (no bubble), else `dout_valid` drops.
- `dout`, `dout_sop`, `dout_eop` stable while `dout_valid&!dout_ready`.

## Timing
- Reset values: all outputs 0, `fifo_level`=0, FSM IDLE, serializer empty.
- Status pulses (`frame_done`, `frame_err`, `len_err`) registered: high the cycle after the causing input edge.
- `fifo_level` updates the edge after write/read; simultaneous write and read on full FIFO: read frees slot first, write accepted, no `ovf`.
- Latency: word accepted at edge k with empty FIFO and idle serializer → `dout_valid` high after edge k+2.
- Throughput: 6 cycles per input word with `dout_ready`=1; sustained input faster than 1/6 fills FIFO.
- `clr` mid-operation: immediate clear of FIFO, serializer, FSM, `ovf`; `dout_valid` low asynchronously.

## Test plan
- `L_stroke`=3, frame of 3 words, `dout_ready`=1 → 18 sub-words in order, `dout_sop` on 1st, `dout_eop` on 18th, `frame_done` once, no errors, first `dout_valid` 2 cycles after first word.
- `L_stroke`=3, frame of 2 words → `len_err` pulse cycle after eop word; 12 sub-words still output with correct sop/eop.
- `dout_ready`=0, 6-word frame back-to-back, DEPTH=4 → 1 word in serializer plus 4 stored, 6th dropped, `ovf`=1, `fifo_level`=4; release ready → 30 sub-words.
- `data_valid` without `sop` in IDLE → `frame_err` pulse, `fifo_level` stays 0, `dout_valid` stays 0.
- `ink` after 2 words of open frame → `frame_err` pulse; next sop/eop frame accepted cleanly; single-word frame (sop&eop same cycle, `L_stroke`=1) → no `len_err`.
- Assert `clr` during serialization at index 3 → `dout_valid`, `fifo_level`, `ovf` to 0 immediately; after release, new frame serializes from index 0.
